// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the instruction-memory request port, the IF/ID handshake and the
//   redirect input of the fetch front end.
//   master : the fetch_queue side (drives imem_req/imem_addr, inst_*, occupancy)
//   slave  : the memory / decode / environment side
//   Ports of the bundle:
//     imem_req, imem_addr      fetch request and address
//     imem_valid, imem_rdata   memory response, one cycle after an accepted request
//     inst_valid, inst_data,
//     inst_pc, inst_ready      queue head to IF/ID with valid/ready handshake
//     redirect_valid,
//     redirect_pc              flush and restart fetch at a new address
//     occupancy                number of valid queue entries
interface fetch_queue_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
);
   logic                      imem_req;
   logic [ADDR_W-1:0]         imem_addr;
   logic                      imem_valid;
   logic [DATA_W-1:0]         imem_rdata;
   logic                      inst_valid;
   logic [DATA_W-1:0]         inst_data;
   logic [ADDR_W-1:0]         inst_pc;
   logic                      inst_ready;
   logic                      redirect_valid;
   logic [ADDR_W-1:0]         redirect_pc;
   logic [$clog2(DEPTH):0]    occupancy;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc, occupancy,
      input  imem_valid, imem_rdata, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, occupancy,
      output imem_valid, imem_rdata, inst_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end: PC sequencer, synchronous instruction-memory
//   request port and a DEPTH-entry {pc, instr} queue feeding IF/ID through a
//   valid/ready handshake. Redirects flush the queue and any in-flight fetch.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-low reset
//     bus    : fetch_queue_if.master (memory port, IF/ID handshake, redirect,
//              occupancy)
//   Optional build macro:
//     FQ_BYPASS_EN : when defined, a response arriving at an empty queue is
//                    presented combinationally on inst_* in the same cycle and
//                    is not enqueued if IF/ID takes it.
module fetch_queue #(
   parameter int unsigned      ADDR_W   = 32,
   parameter int unsigned      DATA_W   = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           reset,
   fetch_queue_if.master bus
);

   localparam int unsigned       PTR_W   = $clog2(DEPTH);
   localparam int unsigned       CNT_W   = PTR_W + 1;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

   // A request accepted in one cycle has its response in the next, so the
   // fetch port only needs to remember whether last cycle issued.
   typedef enum logic {
      FS_IDLE,
      FS_BUSY
   } fetch_state_e;

   fetch_state_e      fs_q, fs_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] last_pc_q, last_pc_d;
   logic [DATA_W-1:0] last_data_q, last_data_d;

   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   logic              run;
   logic              q_empty;
   logic              issue;
   logic              resp_ok;
   logic              byp;
   logic              push;
   logic              pop;
   logic [CNT_W:0]    pending;
   logic              head_valid;
   logic [ADDR_W-1:0] head_pc;
   logic [DATA_W-1:0] head_data;

   always_comb begin
      run     = reset && !bus.redirect_valid;
      q_empty = (count_q == '0);
      pending = {1'b0, count_q} + (CNT_W + 1)'(fs_q == FS_BUSY);
      issue   = run && (pending < (CNT_W + 1)'(DEPTH));

      // The in-flight fetch is killed implicitly: a redirect blocks issue and
      // discards the response landing in its own cycle, so nothing stale is
      // outstanding afterwards.
      resp_ok = run && bus.imem_valid && (fs_q == FS_BUSY);

`ifdef FQ_BYPASS_EN
      byp = resp_ok && q_empty;
`else
      byp = 1'b0;
`endif

      push = resp_ok && !(byp && bus.inst_ready);
      pop  = run && !q_empty && bus.inst_ready;

      head_valid = !q_empty || byp;
      if (!q_empty) begin
         head_pc   = pc_mem_q[rd_ptr_q];
         head_data = data_mem_q[rd_ptr_q];
      end else if (byp) begin
         head_pc   = req_pc_q;
         head_data = bus.imem_rdata;
      end else begin
         head_pc   = last_pc_q;
         head_data = last_data_q;
      end

      bus.imem_req   = issue;
      bus.imem_addr  = fetch_pc_q;
      bus.inst_valid = head_valid;
      bus.inst_pc    = head_pc;
      bus.inst_data  = head_data;
      bus.occupancy  = count_q;

      // Next state.
      fs_d        = issue ? FS_BUSY : FS_IDLE;
      req_pc_d    = issue ? fetch_pc_q : req_pc_q;
      fetch_pc_d  = fetch_pc_q;
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(push);
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      // Remember whatever was last presented so an empty queue holds it.
      last_pc_d   = head_valid ? head_pc : last_pc_q;
      last_data_d = head_valid ? head_data : last_data_q;

      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fs_q        <= FS_IDLE;
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         last_pc_q   <= '0;
         last_data_q <= '0;
      end else begin
         fs_q        <= fs_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         last_pc_q   <= last_pc_d;
         last_data_q <= last_data_d;
      end
   end

   // Storage needs no reset: entries are only read while count_q covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= req_pc_q;
         data_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] KEY    = 32'hA5A5_0000;

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        stray;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_data;
      logic [31:0] exp_occ;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   fetch_queue #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .RESET_PC(32'h0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   vec_t        tbl[$];
   logic [31:0] sb_q[$];
   logic        m_req_q;
   logic [31:0] m_addr_q;
   logic [31:0] model_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst_n, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic stray, input logic req, input logic [31:0] addr,
                      input logic valid, input logic [31:0] pc, input logic zdata,
                      input logic [31:0] occ);
      vec_t v;
      v.rst_n = rst_n; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.stray = stray;
      v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
      v.exp_data = zdata ? 32'h0 : (pc ^ KEY);
      v.exp_occ = occ;
      tbl.push_back(v);
   endtask

   // Inputs for one cycle, applied just after the rising edge. The memory
   // model answers exactly one cycle after a request it saw.
   task automatic drive(input logic rst_n, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic stray);
      reset              = rst_n;
      bus.inst_ready     = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.imem_valid     = m_req_q | stray;
      bus.imem_rdata     = m_req_q ? (m_addr_q ^ KEY) : 32'hDEAD_BEEF;
   endtask

   // Called at the falling edge: scoreboard pop on handshake, push on issue,
   // flush on reset/redirect, and sample the request for the memory model.
   task automatic observe();
      logic [31:0] exp_pc;
      if (reset && !bus.redirect_valid && bus.inst_valid && bus.inst_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
         end else begin
            exp_pc = sb_q.pop_front();
            check("sb_pc", bus.inst_pc, exp_pc);
            check("sb_data", bus.inst_data, exp_pc ^ KEY);
         end
      end
      if (!reset || bus.redirect_valid)
         check("req_blocked", 32'(bus.imem_req), 32'h0);
      if (bus.imem_req) begin
         check("sb_fetch_addr", bus.imem_addr, model_pc);
         sb_q.push_back(model_pc);
         model_pc = model_pc + 32'd4;
      end
      check("occ_bound", 32'(bus.occupancy <= 3'(DEPTH)), 32'h1);
      if (!reset) begin
         sb_q.delete();
         model_pc = 32'h0;
      end else if (bus.redirect_valid) begin
         sb_q.delete();
         model_pc = bus.redirect_pc;
      end
      m_req_q  = bus.imem_req;
      m_addr_q = bus.imem_addr;
   endtask

   initial begin
      logic        r_rst, r_rdy, r_rv;
      logic [31:0] r_pc;

      reset = 1'b0;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = '0;
      m_req_q = 1'b0;
      m_addr_q = '0;
      model_pc = '0;

      //  rst rdy rv rpc            st | req addr           vld pc             z occ
      // Reset state, then streaming with ready high.
      add(0, 1, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         1, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         1, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         1, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h8,         1, 32'h0,         0, 1);
      add(1, 1, 0, 32'h0,         0,  1, 32'hC,         1, 32'h4,         0, 1);
      add(1, 1, 0, 32'h0,         0,  1, 32'h10,        1, 32'h8,         0, 1);
      // Reset with a live head and a response landing in the reset cycle.
      add(0, 0, 0, 32'h0,         0,  0, 32'h14,        1, 32'hC,         0, 1);
      // Ready held low: four requests fill the queue, then issue stops.
      add(1, 0, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         1, 0);
      add(1, 0, 0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         1, 0);
      add(1, 0, 0, 32'h0,         0,  1, 32'h8,         1, 32'h0,         0, 1);
      add(1, 0, 0, 32'h0,         0,  1, 32'hC,         1, 32'h0,         0, 2);
      add(1, 0, 0, 32'h0,         0,  0, 32'h10,        1, 32'h0,         0, 3);
      add(1, 0, 0, 32'h0,         0,  0, 32'h10,        1, 32'h0,         0, 4);
      add(1, 0, 0, 32'h0,         0,  0, 32'h10,        1, 32'h0,         0, 4);
      // Release: drain in order, fetching resumes at 0x10.
      add(1, 1, 0, 32'h0,         0,  0, 32'h10,        1, 32'h0,         0, 4);
      add(1, 1, 0, 32'h0,         0,  1, 32'h10,        1, 32'h4,         0, 3);
      add(1, 1, 0, 32'h0,         0,  1, 32'h14,        1, 32'h8,         0, 2);
      add(1, 1, 0, 32'h0,         0,  1, 32'h18,        1, 32'hC,         0, 2);
      add(1, 1, 0, 32'h0,         0,  1, 32'h1C,        1, 32'h10,        0, 2);
      // Redirect with occupancy 2, fetch in flight, pop and response same cycle.
      add(1, 1, 1, 32'h100,       0,  0, 32'h20,        1, 32'h14,        0, 2);
      add(1, 1, 0, 32'h0,         0,  1, 32'h100,       0, 32'h14,        0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h104,       0, 32'h14,        0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h108,       1, 32'h100,       0, 1);
      add(1, 1, 0, 32'h0,         0,  1, 32'h10C,       1, 32'h104,       0, 1);
      // Redirect to the top of the address space: PC wraps to 0.
      add(1, 1, 1, 32'hFFFFFFFC,  0,  0, 32'h110,       1, 32'h108,       0, 1);
      add(1, 1, 0, 32'h0,         0,  1, 32'hFFFFFFFC,  0, 32'h108,       0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h0,         0, 32'h108,       0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h4,         1, 32'hFFFFFFFC,  0, 1);
      add(1, 1, 0, 32'h0,         0,  1, 32'h8,         1, 32'h0,         0, 1);
      // Back-to-back redirects: the last one wins.
      add(1, 1, 1, 32'h200,       0,  0, 32'hC,         1, 32'h4,         0, 1);
      add(1, 1, 1, 32'h300,       0,  0, 32'h200,       0, 32'h4,         0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h300,       0, 32'h4,         0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h304,       0, 32'h4,         0, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h308,       1, 32'h300,       0, 1);
      // Reset mid-stream with occupancy 3 and a fetch in flight, then a stray
      // response with nothing outstanding.
      add(1, 0, 0, 32'h0,         0,  1, 32'h30C,       1, 32'h304,       0, 1);
      add(1, 0, 0, 32'h0,         0,  1, 32'h310,       1, 32'h304,       0, 2);
      add(0, 0, 0, 32'h0,         0,  0, 32'h314,       1, 32'h304,       0, 3);
      add(1, 1, 0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         1, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h4,         0, 32'h0,         1, 0);
      add(1, 1, 0, 32'h0,         0,  1, 32'h8,         1, 32'h0,         0, 1);
      add(1, 1, 0, 32'h0,         0,  1, 32'hC,         1, 32'h4,         0, 1);

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst_n, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].stray);
         @(negedge clk);
         check($sformatf("r%0d_req", i),   32'(bus.imem_req),   32'(tbl[i].exp_req));
         check($sformatf("r%0d_addr", i),  bus.imem_addr,       tbl[i].exp_addr);
         check($sformatf("r%0d_valid", i), 32'(bus.inst_valid), 32'(tbl[i].exp_valid));
         check($sformatf("r%0d_pc", i),    bus.inst_pc,         tbl[i].exp_pc);
         check($sformatf("r%0d_data", i),  bus.inst_data,       tbl[i].exp_data);
         check($sformatf("r%0d_occ", i),   32'(bus.occupancy),  tbl[i].exp_occ);
         observe();
         @(posedge clk);
         #1;
      end

      // Random ready / redirect / reset traffic checked by the scoreboard.
      for (int c = 0; c < 400; c++) begin
         r_rst = ($urandom_range(0, 39) != 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rv  = ($urandom_range(0, 11) == 0);
         r_pc  = $urandom & 32'hFFFF_FFFC;
         drive(r_rst, r_rdy, r_rv, r_pc, 1'b0);
         @(negedge clk);
         observe();
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined CPU.
- Replaces the bare PC register and combinational fetch with three pieces: a PC sequencer, a synchronous instruction-memory request port, and a DEPTH-entry instruction queue.
- Feeds the IF/ID register through a valid/ready handshake.
- Accepts redirects (branch/jump/jr targets) from ID, which flush both the queue and any in-flight fetch.

Parameters:
ADDR_W, 32, PC / instruction address width
DATA_W, 32, instruction width; PC step is DATA_W/8
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  fetch request this cycle
imem_addr  out  ADDR_W  fetch address (= fetch_pc)
imem_valid  in  1  response valid; exactly 1 cycle after an accepted imem_req
imem_rdata  in  DATA_W  instruction word, qualified by imem_valid
inst_valid  out  1  queue head valid
inst_data  out  DATA_W  queue head instruction
inst_pc  out  ADDR_W  address of queue head instruction
inst_ready  in  1  IF/ID consumes head (low = hold_IFID)
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch address
occupancy  out  $clog2(DEPTH)+1  valid entries in queue

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc=RESET_PC; queue empty; read/write pointers 0; in-flight flag 0.
  - Outputs: imem_req=0, inst_valid=0, occupancy=0, inst_data=0, inst_pc=0.
  - Reset overrides every other input, including during an outstanding fetch; a response arriving in the cycle after reset is discarded.
- Issue rule: imem_req=1 iff reset deasserted, redirect_valid=0, and occupancy + inflight < DEPTH.
  - On issue: fetch_pc <= fetch_pc + DATA_W/8, modulo 2^ADDR_W (wraps to 0 silently).
  - Each queue entry stores {pc, instr}; the pc is latched with the request.
- Response: when imem_valid=1 and inflight=1 and the request was not killed, the entry is written at the tail at that edge.
  - inst_valid rises the following cycle.
  - imem_valid with inflight=0 is ignored.
- Pop: inst_valid && inst_ready advances the head at the edge.
  - Push and pop in the same cycle leave occupancy unchanged and are legal when full or when empty-with-incoming-write.
- Full: occupancy + inflight == DEPTH blocks issue, so an overflow cannot occur.
- Empty: inst_valid=0, and inst_data/inst_pc hold their last values. inst_ready is ignored.
- Redirect (redirect_valid=1 at an edge):
  - Queue flushed (pointers reset, occupancy=0); fetch_pc <= redirect_pc.
  - A request issued in the previous cycle is marked killed, and its response is dropped.
  - No issue in the redirect cycle. The first request goes to redirect_pc in cycle T+1, its data is written at T+2, and inst_valid=1 in T+3.
  - Pop and response in the same cycle as the redirect are discarded; redirect wins.
  - Back-to-back redirects: the last one wins.
- Steady-state throughput: one instruction per cycle when inst_ready is held high and the queue is not full.
- Ordering: instructions are presented strictly in request order with their correct PCs.

Optional Feature:
FQ_BYPASS_EN
- Defined: when the queue is empty and a valid non-killed response arrives, inst_valid/inst_data/inst_pc are driven combinationally from imem_rdata in the same cycle.
  - If inst_ready=1, the word is consumed and is not written to the queue; otherwise it is enqueued normally.
  - Redirect-to-first-valid latency becomes 2 cycles (T+2).
- Undefined: no bypass path; all instructions pass through the queue (latency 3 cycles, as above).

Test Plan:
1. Reset with RESET_PC=0x0, inst_ready=1, memory returns addr^0xA5A50000 -> first imem_req at addr 0x0 in cycle 1; inst_valid from cycle 3; inst_pc sequence 0x0,0x4,0x8, one per cycle, with matching data.
2. Hold inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, occupancy=4, imem_req=0 thereafter; release ready -> 0x0..0xC drained in order, fetching resumes at 0x10.
3. Redirect to 0x100 while a request for 0x8 is in flight and occupancy=2 -> 0x8 response dropped, occupancy=0 next cycle, next imem_addr=0x100, inst_pc=0x100 valid at T+3.
4. Redirect asserted together with inst_ready=1 and imem_valid=1 -> no pop or push takes effect; queue empty; fetch restarts at redirect_pc.
5. redirect_pc=0xFFFFFFFC with ADDR_W=32 -> fetched PCs 0xFFFFFFFC then 0x00000000.
6. Assert reset mid-stream with occupancy=3 and a request in flight -> all outputs 0 next cycle, in-flight response ignored, refetch from RESET_PC.
